// File: rtl/xsr.sv
// Serial shift responder: far end of an xst link. Receives sclk/sdi, shifts
// LSB first with the incoming bit entering at the MSB, and returns data on sdo.
module xsr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        sclk_i,
    input  logic        sdi_i,
    output logic        sdo_o,
    input  logic [63:0] dat_i,
    input  logic        rxreg_we_i,
    input  logic        rxreg_oe_i,
    input  logic [5:0]  bits_i,
    output logic [5:0]  bits_o,
    output logic        idle_o,
    output logic        done_o,
    output logic        ovr_o,
    output logic [63:0] dat_o
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   s;
    logic                   d;
    logic                   s_d;
    logic                   fall;
    logic                   rise;
    logic [63:0]            sr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
            s_d       <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi_i};
            s_d       <= s;
        end
    end

    assign s    = sclk_sync[SYNC_STAGES-1];
    assign d    = sdi_sync[SYNC_STAGES-1];
    assign fall = s_d & ~s;
    assign rise = ~s_d & s;

    assign idle_o = (bits_o == '0);
    assign dat_o  = rxreg_oe_i ? sr : '0;

    // A load wins over any edge detected in the same cycle; sdo only moves on
    // rises so the initiator's sample before the final fall sees the last bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr     <= '1;
            sdo_o  <= 1'b1;
            bits_o <= '0;
            done_o <= 1'b0;
            ovr_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (rxreg_we_i) begin
                sr     <= dat_i;
                sdo_o  <= dat_i[0];
                bits_o <= bits_i;
                ovr_o  <= 1'b0;
            end else if (fall && !idle_o) begin
                sr     <= {d, sr[63:1]};
                bits_o <= bits_o - 6'd1;
                if (bits_o == 6'd1) begin
                    done_o <= 1'b1;
                end
            end else if (rise && !idle_o) begin
                sdo_o <= sr[0];
            end else if (fall) begin
                ovr_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xsr.sv
// Scoreboard bench for xsr: stimulus pushes expectations, a monitor pops them
// on done_o pulses or on an observe strobe. The bench plays the xst initiator.
module tb_xsr;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic        sdo;
    logic [63:0] dat_in = '0;
    logic        we = 1'b0;
    logic        oe = 1'b1;
    logic [5:0]  bits_in = '0;
    logic [5:0]  bits;
    logic        idle;
    logic        done;
    logic        ovr;
    logic [63:0] dat_out;

    xsr #(.SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .sclk_i     (sclk),
        .sdi_i      (sdi),
        .sdo_o      (sdo),
        .dat_i      (dat_in),
        .rxreg_we_i (we),
        .rxreg_oe_i (oe),
        .bits_i     (bits_in),
        .bits_o     (bits),
        .idle_o     (idle),
        .done_o     (done),
        .ovr_o      (ovr),
        .dat_o      (dat_out)
    );

    always #5 clk = ~clk;

    localparam int SEL_DAT   = 0;
    localparam int SEL_BITS  = 1;
    localparam int SEL_SDO   = 2;
    localparam int SEL_IDLE  = 3;
    localparam int SEL_DONE  = 4;
    localparam int SEL_OVR   = 5;
    localparam int SEL_TOP   = 6;
    localparam int SEL_RX    = 7;
    localparam int SEL_DCNT  = 8;

    typedef struct {
        bit          on_done;
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic        strobe = 1'b0;
    logic [63:0] rx = '0;

    function automatic logic [63:0] actual(int sel);
        case (sel)
            SEL_DAT:  return dat_out;
            SEL_BITS: return {58'd0, bits};
            SEL_SDO:  return {63'd0, sdo};
            SEL_IDLE: return {63'd0, idle};
            SEL_DONE: return {63'd0, done};
            SEL_OVR:  return {63'd0, ovr};
            SEL_TOP:  return {56'd0, dat_out[63:56]};
            SEL_RX:   return {56'd0, rx[63:56]};
            SEL_DCNT: return 64'(done_cnt);
            default:  return 'x;
        endcase
    endfunction

    task automatic compare(input exp_t e);
        logic [63:0] a;
        a = actual(e.sel);
        tests++;
        if (a !== e.val) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (q.size() == 0 || !q[0].on_done) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got pulse, expected none at %0t", $time);
            end else begin
                while (q.size() > 0 && q[0].on_done) compare(q.pop_front());
            end
        end
        if (strobe) begin
            while (q.size() > 0 && q[0].on_done) begin
                exp_t e;
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_done (%s): got no pulse, expected one", e.name);
            end
            while (q.size() > 0 && !q[0].on_done) compare(q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_s(input string n, input int sel, input logic [63:0] v);
        exp_t e;
        e.on_done = 1'b0; e.name = n; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    task automatic exp_d(input string n, input int sel, input logic [63:0] v);
        exp_t e;
        e.on_done = 1'b1; e.name = n; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    // Ends one clock later, aligned just after a rising edge.
    task automatic observe();
        strobe = 1'b1;
        @(negedge clk);
        #1 strobe = 1'b0;
        tick(1);
    endtask

    task automatic load(input logic [63:0] v, input logic [5:0] b);
        dat_in  = v;
        bits_in = b;
        we      = 1'b1;
        tick(1);
        we      = 1'b0;
    endtask

    // Initiator bit: drive data with the rise, sample rxd just before the fall.
    task automatic bit_cycle(input logic b);
        sdi  = b;
        sclk = 1'b1;
        tick(8);
        rx   = {sdo, rx[63:1]};
        sclk = 1'b0;
        tick(8);
    endtask

    initial begin
        logic [63:0] tx;
        tx = 64'h0123_4567_89AB_CDEF;

        // Reset values, observed while reset is held.
        tick(3);
        exp_s("rst_dat",  SEL_DAT,  64'hFFFF_FFFF_FFFF_FFFF);
        exp_s("rst_sdo",  SEL_SDO,  64'd1);
        exp_s("rst_idle", SEL_IDLE, 64'd1);
        exp_s("rst_bits", SEL_BITS, 64'd0);
        exp_s("rst_done", SEL_DONE, 64'd0);
        exp_s("rst_ovr",  SEL_OVR,  64'd0);
        observe();
        reset = 1'b0;
        tick(2);

        // Full-duplex 8-bit frame.
        load(64'hFEDC_BA98_7654_3255, 6'd8);
        exp_s("ld_bits", SEL_BITS, 64'd8);
        exp_s("ld_sdo",  SEL_SDO,  64'd1);
        exp_s("ld_idle", SEL_IDLE, 64'd0);
        observe();
        exp_d("done_bits", SEL_BITS, 64'd0);
        exp_d("done_idle", SEL_IDLE, 64'd1);
        for (int i = 0; i < 8; i++) bit_cycle(tx[i]);
        tick(4);
        exp_s("frm_top",  SEL_TOP,  64'hEF);
        exp_s("frm_dat",  SEL_DAT,  64'hEFFE_DCBA_9876_5432);
        exp_s("frm_rx",   SEL_RX,   64'h55);
        exp_s("frm_dcnt", SEL_DCNT, 64'd1);
        exp_s("frm_hold", SEL_SDO,  64'd0);
        observe();

        // Overrun: a clock pulse while idle.
        sclk = 1'b1;
        tick(8);
        sclk = 1'b0;
        tick(8);
        exp_s("ovr_set", SEL_OVR, 64'd1);
        exp_s("ovr_dat", SEL_DAT, 64'hEFFE_DCBA_9876_5432);
        exp_s("ovr_sdo", SEL_SDO, 64'd0);
        observe();
        load(64'h0, 6'd5);
        exp_s("ovr_clr", SEL_OVR,  64'd0);
        exp_s("lat_b0",  SEL_BITS, 64'd5);
        observe();

        // Edge latency: fall first sampled at E acts at E+2.
        sclk = 1'b1;
        tick(8);
        sclk = 1'b0;
        tick(1);
        exp_s("lat_e0", SEL_BITS, 64'd5);
        observe();
        exp_s("lat_e1", SEL_BITS, 64'd5);
        observe();
        exp_s("lat_e2", SEL_BITS, 64'd4);
        observe();

        // Mid-frame load aborts without done.
        load(64'hFFFF_FFFF_FFFF_FFFF, 6'd8);
        exp_s("mid_sdo1", SEL_SDO, 64'd1);
        observe();
        for (int i = 0; i < 3; i++) bit_cycle(1'b0);
        exp_s("mid_bits3", SEL_BITS, 64'd5);
        observe();
        load(64'hA, 6'd4);
        exp_s("mid_bits", SEL_BITS, 64'd4);
        exp_s("mid_sdo",  SEL_SDO,  64'd0);
        exp_s("mid_idle", SEL_IDLE, 64'd0);
        observe();

        // Load colliding with a detected fall: load result only.
        sclk = 1'b1;
        tick(8);
        sclk = 1'b0;
        tick(2);
        dat_in  = 64'h3;
        bits_in = 6'd6;
        we      = 1'b1;
        tick(1);
        we      = 1'b0;
        exp_s("col_bits", SEL_BITS, 64'd6);
        exp_s("col_ovr",  SEL_OVR,  64'd0);
        exp_s("col_sdo",  SEL_SDO,  64'd1);
        observe();
        tick(4);
        exp_s("col_keep", SEL_BITS, 64'd6);
        observe();

        // Zero-length load stays idle; dat_o gated by oe.
        load(64'h1234, 6'd0);
        tick(4);
        exp_s("zl_idle", SEL_IDLE, 64'd1);
        exp_s("zl_bits", SEL_BITS, 64'd0);
        exp_s("zl_dat",  SEL_DAT,  64'h1234);
        observe();
        oe = 1'b0;
        exp_s("oe_off", SEL_DAT, 64'd0);
        observe();
        tick(4);
        exp_s("end_dcnt", SEL_DCNT, 64'd1);
        observe();
        observe();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
